// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and instruction-memory write bus of the program loader.
// The master side is the byte source / memory model. The slave side is the loader.
interface prog_loader_if #(parameter int ADDR_W = 10);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [8:0]        im_wdata;
    modport master (output in_valid, in_data, input in_ready, im_we, im_addr, im_wdata);
    modport slave  (input in_valid, in_data, output in_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: parses a framed byte stream (length, 9-bit words, XOR checksum) into instruction
// memory writes from address 0, holding the core in reset while loading.
module prog_loader #(parameter int ADDR_W = 10) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    prog_loader_if.slave bus,
    output logic        cpu_hold,
    output logic        done,
    output logic [1:0]  err,
    output logic        illegal_seen
);
    localparam logic [2:0] IDLE = 3'd0, LEN_LO = 3'd1, LEN_HI = 3'd2, INS_LO = 3'd3,
                           INS_HI = 3'd4, CSUM = 3'd5, DONE = 3'd6, ERR = 3'd7;
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    logic [2:0]        state_q, state_d;
    logic [7:0]        lo_q, lo_d, csum_q, csum_d;
    logic [ADDR_W:0]   len_q, len_d, count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        wdata_q, wdata_d;
    logic              we_q, we_d, ill_q, ill_d;
    logic [1:0]        err_q, err_d;
    logic              xfer, last;
    logic [15:0]       n;

    assign bus.in_ready = (state_q >= LEN_LO) && (state_q <= CSUM);
    assign bus.im_we    = we_q;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = wdata_q;
    assign cpu_hold     = !(state_q == IDLE || state_q == DONE || state_q == ERR);
    assign done         = state_q == DONE;
    assign err          = err_q;
    assign illegal_seen = ill_q;

    assign xfer = bus.in_valid & bus.in_ready;
    assign n    = {bus.in_data, lo_q};
    assign last = (count_q + 1'b1) == len_q;

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        csum_d  = (xfer && state_q != CSUM) ? csum_q ^ bus.in_data : csum_q;
        len_d   = len_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        we_d    = 1'b0;
        // address advances after each write but saturates so a full-depth load never wraps
        addr_d  = (we_q && addr_q != '1) ? addr_q + 1'b1 : addr_q;
        ill_d   = ill_q | (we_q && !wdata_q[0] && wdata_q[4:1] >= 4'b1110);
        case (state_q)
            IDLE, DONE, ERR: if (start) begin
                state_d = LEN_LO;
                count_d = '0;
                csum_d  = '0;
                addr_d  = '0;
                err_d   = 2'd0;
                ill_d   = 1'b0;
            end
            LEN_LO: if (xfer) begin
                lo_d    = bus.in_data;
                state_d = LEN_HI;
            end
            LEN_HI: if (xfer) begin
                len_d   = n[ADDR_W:0];
                state_d = ({1'b0, n} > DEPTH) ? ERR : (n == '0) ? CSUM : INS_LO;
                err_d   = ({1'b0, n} > DEPTH) ? 2'd2 : err_q;
            end
            INS_LO: if (xfer) begin
                lo_d    = bus.in_data;
                state_d = INS_HI;
            end
            INS_HI: if (xfer) begin
                if (|bus.in_data[7:1]) begin
                    state_d = ERR;
                    err_d   = 2'd1;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = {bus.in_data[0], lo_q};
                    count_d = count_q + 1'b1;
                    state_d = last ? CSUM : INS_LO;
                end
            end
            CSUM: if (xfer) begin
                state_d = (bus.in_data == csum_q) ? DONE : ERR;
                err_d   = (bus.in_data == csum_q) ? 2'd0 : 2'd3;
            end
            default: ;
        endcase
        if (abort) begin
            state_d = IDLE;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            csum_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            csum_q  <= csum_d;
            len_q   <= len_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random and directed frames checked against a frame-level parsing model.
module tb_prog_loader;
    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic       cpu_hold, done, illegal_seen;
    logic [1:0] err;
    int         n_tests = 0, n_fail = 0;

    prog_loader_if #(.ADDR_W(10)) bus ();
    prog_loader #(.ADDR_W(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .bus(bus),
        .cpu_hold(cpu_hold), .done(done), .err(err), .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    logic [7:0]  frame_q[$];
    logic [18:0] exp_q[$], obs_q[$];
    logic [1:0]  e_err;
    logic        e_done, e_ill;
    int          e_used, used;

    always @(negedge clk) if (bus.im_we === 1'b1) obs_q.push_back({bus.im_addr, bus.im_wdata});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Parses the frame by its byte-level rules and predicts writes, flags and bytes consumed.
    task automatic model();
        int n, k;
        logic [7:0] x, lo, hi;
        exp_q.delete();
        e_err = 2'd0;
        e_ill = 1'b0;
        n = int'({frame_q[1], frame_q[0]});
        x = frame_q[0] ^ frame_q[1];
        k = 2;
        if (n > 1024) e_err = 2'd2;
        else begin
            for (int w = 0; w < n && e_err == 0; w++) begin
                lo = frame_q[k];
                hi = frame_q[k+1];
                k += 2;
                if (hi[7:1] != 0) e_err = 2'd1;
                else begin
                    x ^= lo ^ hi;
                    exp_q.push_back({10'(w), hi[0], lo});
                    if (!lo[0] && lo[4:1] >= 4'd14) e_ill = 1'b1;
                end
            end
            if (e_err == 0) begin
                e_err = (frame_q[k] == x) ? 2'd0 : 2'd3;
                k++;
            end
        end
        e_used = k;
        e_done = e_err == 0;
    endtask

    // kind: 0 good, 1 bad HI byte, 2 bad checksum, 3 length overflow
    task automatic build(input int n, input int kind);
        logic [7:0] x, lo, hi;
        int bad, len;
        frame_q.delete();
        len = (kind == 3) ? $urandom_range(1025, 65535) : n;
        frame_q.push_back(len[7:0]);
        frame_q.push_back(len[15:8]);
        if (kind == 3) frame_q.push_back(8'($urandom));
        else begin
            bad = $urandom_range(0, (n > 0) ? n - 1 : 0);
            x = len[7:0] ^ len[15:8];
            for (int j = 0; j < n; j++) begin
                lo = 8'($urandom);
                if ($urandom_range(0, 5) == 0) lo = {3'($urandom), 4'b1110 | 4'($urandom_range(0, 1)), 1'b0};
                hi = 8'($urandom_range(0, 1));
                if (kind == 1 && j == bad) hi[7:1] = 7'($urandom_range(1, 127));
                frame_q.push_back(lo);
                frame_q.push_back(hi);
                x ^= lo ^ hi;
            end
            frame_q.push_back(x ^ ((kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00));
        end
    endtask

    task automatic run_frame(input int lim, input bit gaps);
        int i = 0, cyc = 0;
        obs_q.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (i < frame_q.size() && i < lim && bus.in_ready) begin
            if (++cyc > 20000) begin
                chk("timeout", 32'(cyc), 32'd20000);
                break;
            end
            bus.in_valid = !gaps || $urandom_range(0, 3) != 0;
            bus.in_data  = frame_q[i];
            @(posedge clk);
            if (bus.in_valid) i++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        used = i;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_used"}, 32'(used), 32'(e_used));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'(e_done));
        chk({tag, "_err"}, 32'(err), 32'(e_err));
        chk({tag, "_ill"}, 32'(illegal_seen), 32'(e_ill));
        chk({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++)
            chk({tag, "_wr"}, 32'(obs_q[j]), 32'(exp_q[j]));
    endtask

    task automatic do_frame(input string tag, input bit gaps);
        model();
        run_frame(1 << 30, gaps);
        check_frame(tag);
    endtask

    task automatic interrupt(input bit use_reset);
        int lim, k;
        build(8, 0);
        model();
        lim = $urandom_range(3, 17);
        k = (lim - 2) / 2;
        run_frame(lim, 1'b1);
        #2;
        if (use_reset) begin
            reset_n = 1'b0;
            #1;
            chk("rst_we", 32'(bus.im_we), 32'd0);
            chk("rst_hold", 32'(cpu_hold), 32'd0);
            chk("rst_addr", 32'(bus.im_addr), 32'd0);
        end else abort = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        abort = 1'b0;
        chk("int_hold", 32'(cpu_hold), 32'd0);
        chk("int_ready", 32'(bus.in_ready), 32'd0);
        repeat (10) @(negedge clk);
        chk("int_nwr", 32'(obs_q.size()), 32'(k));
        for (int j = 0; j < obs_q.size() && j < k; j++) chk("int_wr", 32'(obs_q[j]), 32'(exp_q[j]));
        chk("int_done", 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(bus.im_we), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ill", 32'(illegal_seen), 32'd0);
        chk("rst_addr", 32'(bus.im_addr), 32'd0);
        chk("rst_wdata", 32'(bus.im_wdata), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        frame_q = {8'h02, 8'h00, 8'h07, 8'h00, 8'h3F, 8'h01, 8'h3B};
        do_frame("t1", 1'b0);
        if (obs_q.size() == 2) begin
            chk("t1_w0", 32'(obs_q[0]), {13'd0, 10'd0, 9'h007});
            chk("t1_w1", 32'(obs_q[1]), {13'd0, 10'd1, 9'h13F});
        end
        frame_q = {8'h00, 8'h00, 8'h00};
        do_frame("t2", 1'b0);
        frame_q = {8'h01, 8'h04, 8'h00};
        do_frame("t3", 1'b1);
        frame_q = {8'h01, 8'h00, 8'h55, 8'h02, 8'h56};
        do_frame("t4a", 1'b0);
        frame_q = {8'h01, 8'h00, 8'h55, 8'h01, 8'h00};
        do_frame("t4b", 1'b0);
        frame_q = {8'h01, 8'h00, 8'h1C, 8'h00, 8'h1D};
        do_frame("t5", 1'b1);
        build(1024, 0);
        do_frame("full", 1'b1);

        for (int f = 0; f < 30; f++) begin
            build($urandom_range(1, 40), $urandom_range(0, 3));
            do_frame("rnd", 1'b1);
        end
        for (int f = 0; f < 8; f++) interrupt(f[0]);
        build(5, 0);
        do_frame("post", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
